// File: rtl/spi_word_rx_pkg.sv
// Shared definitions for the SPI word receive path and its DAC transmit sibling.
package spi_word_rx_pkg;

  // Word width used on both the host-to-FPGA and FPGA-to-DAC SPI links.
  localparam int SPI_WORD_WIDTH = 24;

  // Receiver frame state.
  typedef enum logic [1:0] {
    sm_wait_idle = 2'd0,
    sm_idle      = 2'd1,
    sm_receiving = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_word_rx_sync_edge.sv
// 1-bit synchroniser chain plus history flop; gives synced level and edges.
// Flops reset to 1 so idle-high CS/SCK lines do not produce a false edge.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // Shift the asynchronous input through the chain, then into history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_word_rx.sv
// SPI slave word receiver: oversamples CS/SCK/MOSI, shifts MSB first on SCK
// falls and reports each CS-delimited frame as a valid word or a frame error.
module spi_word_rx
  import spi_word_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_WORD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_Clock,
  input  logic                  i_SPI_Data,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Data_Valid,
  output logic                  o_Frame_Error,
  output logic                  o_Busy
);

  localparam int              CW       = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(DATA_WIDTH + 1);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_edges;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(i_Clock), .rst(i_Reset), .d(i_SPI_CS),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(i_Clock), .rst(i_Reset), .d(i_SPI_Clock),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  // MOSI only needs the matching delay so it lines up with the SCK fall.
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(i_Clock), .rst(i_Reset), .d(i_SPI_Data),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = &{1'b0, sck_level, sck_rise, mosi_rise, mosi_fall};

  // Marks when the CS synchroniser holds a sample taken after reset, so
  // the reset-value 1s are not mistaken for an idle bus.
  logic [SYNC_STAGES:0] vld_pipe;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
  end

  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         cnt;

  // Frame FSM with registered word, strobes and busy flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= sm_wait_idle;
      shift         <= '0;
      cnt           <= '0;
      o_Data        <= '0;
      o_Data_Valid  <= 1'b0;
      o_Frame_Error <= 1'b0;
      o_Busy        <= 1'b0;
    end else begin
      o_Data_Valid  <= 1'b0;
      o_Frame_Error <= 1'b0;
      case (state)
        sm_wait_idle: begin
          if (vld_pipe[SYNC_STAGES] && cs_level) state <= sm_idle;
        end
        sm_idle: begin
          if (cs_fall) begin
            shift  <= '0;
            cnt    <= '0;
            o_Busy <= 1'b1;
            state  <= sm_receiving;
          end
        end
        sm_receiving: begin
          // CS rise wins over an SCK fall in the same cycle.
          if (cs_rise) begin
            if (cnt == CNT_FULL) begin
              o_Data       <= shift;
              o_Data_Valid <= 1'b1;
            end else begin
              o_Frame_Error <= 1'b1;
            end
            o_Busy <= 1'b0;
            state  <= sm_idle;
          end else if (sck_fall) begin
            shift <= {shift[DATA_WIDTH-2:0], mosi_level};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        default: state <= sm_wait_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_word_rx.sv
// Scoreboard bench for spi_word_rx: SPI master tasks push expected results,
// a negedge monitor pops and compares on every strobe.
module tb_spi_word_rx;

  localparam int DW = 24;
  localparam int SS = 2;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b1, sck = 1'b1, mosi = 1'b0;
  logic [DW-1:0] data;
  logic          dv, fe, busy;

  spi_word_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_SPI_CS(cs), .i_SPI_Clock(sck),
    .i_SPI_Data(mosi), .o_Data(data), .o_Data_Valid(dv),
    .o_Frame_Error(fe), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          q[$];
  logic [DW-1:0] last_good = '0;
  int            rise_cyc = 0;
  bit            prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic bitof(input logic [DW-1:0] w, input int i);
    if (i < DW) return w[DW-1-i];
    return 1'($urandom_range(0, 1));
  endfunction

  // One CS-delimited frame of nbits SCK falls; MOSI changes while SCK is high.
  task automatic send(input logic [DW-1:0] w, input int nbits, input int half);
    exp_t e;
    chk("busy_idle", 32'(busy), 32'd0);
    cs   = 1'b0;
    mosi = bitof(w, 0);
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == 1) chk("busy_mid", 32'(busy), 32'd1);
      sck = 1'b0;
      tick(half);
      sck  = 1'b1;
      mosi = bitof(w, i + 1);
      tick(half);
    end
    cs       = 1'b1;
    rise_cyc = cyc;
    if (nbits == DW) begin
      e.err = 1'b0; e.data = w; last_good = w;
    end else begin
      e.err = 1'b1; e.data = last_good;
    end
    q.push_back(e);
    tick(half);
  endtask

  // Reset lands after 10 bits with CS low; the rest of that frame must vanish.
  task automatic reset_mid_frame(input int half);
    cs   = 1'b0;
    mosi = 1'b1;
    tick(half);
    for (int i = 0; i < DW; i++) begin
      if (i == 10) begin
        rst = 1'b1;
        tick(2);
        chk("rst_mid_data", 32'(data), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        last_good = '0;
        rst = 1'b0;
      end
      sck = 1'b0;
      tick(half);
      sck  = 1'b1;
      mosi = 1'($urandom_range(0, 1));
      tick(half);
    end
    cs = 1'b1;
    tick(half + 4);
  endtask

  // Checks every strobe against the scoreboard, its width and its latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_strobe) chk("strobe_width", 32'({dv, fe}), 32'd0);
      if (dv || fe) begin
        chk("strobe_excl", 32'(dv & fe), 32'd0);
        chk("busy_at_strobe", 32'(busy), 32'd0);
        chk("latency", 32'(cyc - rise_cyc), 32'(SS + 1));
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got dv=%b fe=%b expected none", dv, fe);
        end else begin
          e = q.pop_front();
          chk("kind_err", 32'(fe), 32'(e.err));
          chk("data", 32'(data), 32'(e.data));
        end
      end
      prev_strobe = dv | fe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    logic [DW-1:0] w;
    int            nb;
    rst = 1'b1;
    tick(3);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_err", 32'(fe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(6);

    send(24'hA5C30F, DW, 5);
    send(24'h000001, DW, 5);
    send(24'hFFFFFE, DW, 5);
    send(DW'($urandom), 23, 4);
    send(DW'($urandom), 25, 4);
    send(DW'($urandom), 56, 3);
    tick(4);
    chk("data_kept", 32'(data), 32'h00FFFFFE);

    reset_mid_frame(4);
    send(24'h123456, DW, 4);

    for (int i = 0; i < 8; i++) begin
      sck = 1'b0;
      tick(4);
      sck = 1'b1;
      tick(4);
    end
    send(24'h800000, DW, 4);
    tick(4);
    chk("data_800000", 32'(data), 32'h00800000);

    for (int i = 0; i < 30; i++) begin
      w  = DW'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : DW;
      send(w, nb, int'($urandom_range(SS + 1, 8)));
      tick(int'($urandom_range(0, 5)));
    end

    tick(20);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_data", 32'(data), 32'(last_good));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
